// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port, variable-latency memory between instruction fetch and the
// MEM stage. MEM always wins; stall_mem freezes the pipeline while a load/store is pending.
module mem_port_arbiter #(
   parameter int WORD_LEN = 32,
   parameter int TIMEOUT  = 64,
   parameter int CNT_W    = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [WORD_LEN-1:0] if_addr,
   input  logic                if_flush,
   input  logic                if_hold_ext,
   input  logic                mem_r_en,
   input  logic                mem_w_en,
   input  logic [WORD_LEN-1:0] mem_addr,
   input  logic [WORD_LEN-1:0] mem_wdata,
   output logic                bus_req,
   output logic                bus_we,
   output logic [WORD_LEN-1:0] bus_addr,
   output logic [WORD_LEN-1:0] bus_wdata,
   input  logic [WORD_LEN-1:0] bus_rdata,
   input  logic                bus_ack,
   output logic                if_valid,
   output logic [WORD_LEN-1:0] if_rdata,
   output logic                mem_done,
   output logic [WORD_LEN-1:0] mem_rdata,
   output logic                stall_mem,
   output logic                bus_err
);

   typedef enum logic [1:0] {IDLE, MEM_ACC, IF_ACC} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             drop;
   logic             mem_pend;
   logic             if_consume;
   logic             timeout;

   // mem_done masks the request so the finished instruction is not reissued
   assign mem_pend   = (mem_r_en | mem_w_en) & ~mem_done;
   assign stall_mem  = mem_pend;
   assign if_consume = if_valid & ~if_hold_ext & ~mem_pend;
   assign timeout    = (wait_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         drop      <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         if_valid  <= 1'b0;
         if_rdata  <= '0;
         mem_done  <= 1'b0;
         mem_rdata <= '0;
         bus_err   <= 1'b0;
      end else begin
         mem_done <= 1'b0;
         if (if_flush || if_consume)
            if_valid <= 1'b0;

         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (mem_pend) begin
                  bus_addr  <= mem_addr;
                  bus_we    <= mem_w_en;
                  bus_wdata <= mem_wdata;
                  bus_req   <= 1'b1;
                  state     <= MEM_ACC;
               end else if (if_req && !if_valid) begin
                  bus_addr <= if_addr;
                  bus_we   <= 1'b0;
                  bus_req  <= 1'b1;
                  drop     <= if_flush;
                  state    <= IF_ACC;
               end
            end

            MEM_ACC: begin
               if (bus_ack) begin
                  bus_req  <= 1'b0;
                  bus_we   <= 1'b0;
                  if (!bus_we)
                     mem_rdata <= bus_rdata;
                  mem_done <= 1'b1;
                  state    <= IDLE;
               end else if (timeout) begin
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  bus_err   <= 1'b1;
                  mem_done  <= 1'b1;
                  mem_rdata <= '0;
                  state     <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            IF_ACC: begin
               // a flush landing with the ack also discards the returning word
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  drop    <= 1'b0;
                  state   <= IDLE;
                  if (!drop && !if_flush) begin
                     if_rdata <= bus_rdata;
                     if_valid <= 1'b1;
                  end
               end else if (timeout) begin
                  bus_req <= 1'b0;
                  bus_err <= 1'b1;
                  drop    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
                  if (if_flush)
                     drop <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by randomized traffic, each cycle compared against a
// transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;

   localparam int W  = 32;
   localparam int TO = 8;
   localparam int CW = 7;

   logic         clk = 1'b0;
   logic         rst;
   logic         if_req, if_flush, if_hold_ext, mem_r_en, mem_w_en, bus_ack;
   logic [W-1:0] if_addr, mem_addr, mem_wdata, bus_rdata;
   logic         bus_req, bus_we, if_valid, mem_done, stall_mem, bus_err;
   logic [W-1:0] bus_addr, bus_wdata, if_rdata, mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WORD_LEN(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_hold_ext(if_hold_ext),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .if_valid(if_valid), .if_rdata(if_rdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .stall_mem(stall_mem), .bus_err(bus_err)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int n_stall  = 0;
   bit prev_pend;

   // reference model: one outstanding access described as a transaction record
   bit           busy, is_mem, a_we, discard;
   int           waited;
   logic [W-1:0] m_bus_addr, m_bus_wdata, m_if_rdata, m_mem_rdata;
   bit           m_if_valid, m_done, m_err;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      busy = 0; is_mem = 0; a_we = 0; discard = 0; waited = 0;
      m_bus_addr = '0; m_bus_wdata = '0; m_if_rdata = '0; m_mem_rdata = '0;
      m_if_valid = 0; m_done = 0; m_err = 0;
   endfunction

   function automatic bit model_pend();
      return (mem_r_en | mem_w_en) & !m_done;
   endfunction

   function automatic void model_step();
      bit pend     = model_pend();
      bit consumed = m_if_valid & !if_hold_ext & !pend;
      bit nv       = m_if_valid & !consumed & !if_flush;
      bit nd       = 0;
      if (!busy) begin
         if (pend) begin
            busy = 1; is_mem = 1; a_we = mem_w_en; waited = 0;
            m_bus_addr = mem_addr; m_bus_wdata = mem_wdata;
         end else if (if_req && !m_if_valid) begin
            busy = 1; is_mem = 0; a_we = 0; waited = 0;
            m_bus_addr = if_addr; discard = if_flush;
         end
      end else if (bus_ack) begin
         busy = 0;
         if (is_mem) begin
            nd = 1;
            if (!a_we) m_mem_rdata = bus_rdata;
         end else if (!discard && !if_flush) begin
            nv = 1; m_if_rdata = bus_rdata;
         end
         discard = 0;
      end else if (waited == TO - 1) begin
         busy = 0; m_err = 1; discard = 0;
         if (is_mem) begin nd = 1; m_mem_rdata = '0; end
      end else begin
         waited++;
         if (!is_mem && if_flush) discard = 1;
      end
      m_if_valid = nv;
      m_done     = nd;
   endfunction

   task automatic check_outputs();
      chk("bus_req",   W'(bus_req),  W'(busy));
      chk("bus_we",    W'(bus_we),   W'(busy & a_we));
      chk("bus_addr",  bus_addr,     m_bus_addr);
      chk("bus_wdata", bus_wdata,    m_bus_wdata);
      chk("if_valid",  W'(if_valid), W'(m_if_valid));
      chk("if_rdata",  if_rdata,     m_if_rdata);
      chk("mem_done",  W'(mem_done), W'(m_done));
      chk("mem_rdata", mem_rdata,    m_mem_rdata);
      chk("bus_err",   W'(bus_err),  W'(m_err));
   endtask

   task automatic clr();
      if_req = 0; if_addr = '0; if_flush = 0; if_hold_ext = 0;
      mem_r_en = 0; mem_w_en = 0; mem_addr = '0; mem_wdata = '0;
      bus_ack = 0; bus_rdata = '0;
   endtask

   // inputs are set by the caller; stall is checked before the edge, registers after it
   task automatic tick();
      #1;
      prev_pend = model_pend();
      chk("stall_mem", W'(stall_mem), W'(prev_pend));
      if (stall_mem) n_stall++;
      @(posedge clk);
      model_step();
      #1 check_outputs();
   endtask

   task automatic do_reset();
      rst = 0;
      clr();
      model_reset();
      prev_pend = 0;
      #1 check_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1;
   endtask

   initial begin
      int stuck;
      clr();
      do_reset();

      // single fetch, ack one cycle after bus_req
      if_req = 1; if_addr = 32'h0; if_hold_ext = 1;
      tick();
      chk("f1_bus_addr", bus_addr, 32'h0);
      tick();
      bus_ack = 1; bus_rdata = 32'h2001_0005;
      tick();
      bus_ack = 0;
      chk("f1_if_valid", W'(if_valid), 32'h1);
      chk("f1_if_rdata", if_rdata, 32'h2001_0005);
      if_hold_ext = 0; if_req = 0;
      tick();
      chk("f1_consumed", W'(if_valid), 32'h0);

      // load with three wait cycles
      n_stall = 0;
      mem_r_en = 1; mem_addr = 32'h400;
      repeat (4) tick();
      bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
      tick();
      bus_ack = 0;
      chk("ld_done", W'(mem_done), 32'h1);
      chk("ld_rdata", mem_rdata, 32'hDEAD_BEEF);
      tick();
      chk("ld_no_reissue", W'(bus_req), 32'h0);
      chk("ld_stall_cycles", W'(n_stall), 32'd5);
      mem_r_en = 0;

      // two back-to-back stores with immediate ack
      mem_w_en = 1; mem_addr = 32'h100; mem_wdata = 32'h11;
      tick();
      chk("st1_we", W'(bus_we), 32'h1);
      chk("st1_wdata", bus_wdata, 32'h11);
      bus_ack = 1; tick(); bus_ack = 0;
      tick();
      chk("st_gap", W'(bus_req), 32'h0);
      mem_addr = 32'h104; mem_wdata = 32'h22;
      tick();
      chk("st2_addr", bus_addr, 32'h104);
      chk("st2_wdata", bus_wdata, 32'h22);
      bus_ack = 1; tick(); bus_ack = 0;
      chk("st2_done", W'(mem_done), 32'h1);
      tick();
      mem_w_en = 0;

      // fetch and store together: store first, fetch after mem_done
      if_req = 1; if_addr = 32'h8; mem_w_en = 1; mem_addr = 32'h200; mem_wdata = 32'h55;
      tick();
      chk("pri_addr", bus_addr, 32'h200);
      bus_ack = 1; tick(); bus_ack = 0;
      chk("pri_no_ivalid", W'(if_valid), 32'h0);
      tick();
      chk("pri_fetch_addr", bus_addr, 32'h8);
      mem_w_en = 0;
      bus_ack = 1; bus_rdata = 32'h1234; tick(); bus_ack = 0;
      chk("pri_ivalid", W'(if_valid), 32'h1);
      if_req = 0;
      tick();

      // flush during a fetch discards the returning word
      if_req = 1; if_addr = 32'hC;
      tick();
      if_flush = 1; tick(); if_flush = 0;
      tick();
      bus_ack = 1; bus_rdata = 32'hFFFF_FFFF; tick(); bus_ack = 0;
      chk("fl_ivalid", W'(if_valid), 32'h0);
      chk("fl_rdata", if_rdata, 32'h1234);
      if_addr = 32'h10;
      tick();
      chk("fl_next_addr", bus_addr, 32'h10);
      bus_ack = 1; bus_rdata = 32'hCAFE_F00D; tick(); bus_ack = 0;
      chk("fl_next_rdata", if_rdata, 32'hCAFE_F00D);
      if_req = 0;

      // load timeout
      mem_r_en = 1; mem_addr = 32'h300;
      tick();
      repeat (7) tick();
      chk("to_still_req", W'(bus_req), 32'h1);
      tick();
      chk("to_abort", W'(bus_req), 32'h0);
      chk("to_err", W'(bus_err), 32'h1);
      chk("to_rdata", mem_rdata, 32'h0);
      tick();
      mem_r_en = 0;

      // reset in the middle of an access
      mem_r_en = 1; mem_addr = 32'h500;
      tick();
      #2;
      rst = 0;
      #1;
      chk("rst_req", W'(bus_req), 32'h0);
      chk("rst_err", W'(bus_err), 32'h0);
      do_reset();

      // randomized traffic
      stuck = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!prev_pend) begin
            mem_r_en = 0; mem_w_en = 0;
            case ($urandom_range(0, 5))
               0: mem_r_en = 1;
               1: mem_w_en = 1;
               default: ;
            endcase
            mem_addr  = $urandom & 32'hFFFF_FFFC;
            mem_wdata = $urandom;
         end
         if_req      = ($urandom_range(0, 3) != 0);
         if_addr     = $urandom & 32'hFFFF_FFFC;
         if_flush    = ($urandom_range(0, 15) == 0);
         if_hold_ext = ($urandom_range(0, 3) == 0);
         if (stuck > 0) stuck--;
         else if ($urandom_range(0, 149) == 0) stuck = 12;
         bus_ack   = busy && (stuck == 0) && ($urandom_range(0, 2) == 0);
         bus_rdata = $urandom;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
